// File: rtl/gate_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gate_pkg
// Description : Gate-mode and sweep-state encodings shared by the sweep block.
// Revision    : 1.0 - initial release
// ============================================================================
package gate_pkg;

    localparam logic [2:0] c_mode_and  = 3'd0;
    localparam logic [2:0] c_mode_or   = 3'd1;
    localparam logic [2:0] c_mode_xor  = 3'd2;
    localparam logic [2:0] c_mode_nand = 3'd3;
    localparam logic [2:0] c_mode_nor  = 3'd4;
    localparam logic [2:0] c_mode_xnor = 3'd5;
    localparam logic [2:0] c_mode_buf  = 3'd6;
    localparam logic [2:0] c_mode_zero = 3'd7;

    typedef enum logic [2:0] {
        MODE_AND  = c_mode_and,
        MODE_OR   = c_mode_or,
        MODE_XOR  = c_mode_xor,
        MODE_NAND = c_mode_nand,
        MODE_NOR  = c_mode_nor,
        MODE_XNOR = c_mode_xnor,
        MODE_BUF  = c_mode_buf,
        MODE_ZERO = c_mode_zero
    } gate_mode_e;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_drive = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = c_st_idle,
        ST_DRIVE = c_st_drive,
        ST_DONE  = c_st_done
    } sweep_state_e;

endpackage
`default_nettype wire

// File: rtl/logic_gate_sweep_if.sv
`default_nettype none
// ============================================================================
// Module      : logic_gate_sweep_if
// Description : Control/result bundle of the gate sweep block.
// Revision    : 1.0 - initial release
// ============================================================================
interface logic_gate_sweep_if #(
    parameter int N_IN = 2
);
    logic                   start;
    logic [2:0]             mode;
    logic [N_IN-1:0]        vec_o;
    logic                   out_o;
    logic                   out_valid;
    logic                   busy;
    logic                   done;
    logic [(2**N_IN)-1:0]   truth_o;

    modport master (
        output start, mode,
        input  vec_o, out_o, out_valid, busy, done, truth_o
    );

    modport slave (
        input  start, mode,
        output vec_o, out_o, out_valid, busy, done, truth_o
    );
endinterface
`default_nettype wire

// File: rtl/gate_eval.sv
`default_nettype none
// ============================================================================
// Module      : gate_eval
// Description : Combinational N-input gate selected by a 3-bit mode.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_eval
    import gate_pkg::*;
#(
    parameter int N_IN = 2
) (
    input  wire logic [N_IN-1:0] vec,
    input  gate_mode_e           mode,
    output logic                 y
);
    // XNOR is a chain of 2-input XNOR gates: N_IN-1 inversions on top of parity.
    localparam logic c_xnor_flip = ((N_IN - 1) % 2) == 1;

    always_comb begin
        y = 1'b0;
        case (mode)
            MODE_AND:  y = &vec;
            MODE_OR:   y = |vec;
            MODE_XOR:  y = ^vec;
            MODE_NAND: y = ~&vec;
            MODE_NOR:  y = ~|vec;
            MODE_XNOR: y = (^vec) ^ c_xnor_flip;
            MODE_BUF:  y = vec[0];
            MODE_ZERO: y = 1'b0;
            default:   y = 1'b0;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/logic_gate_sweep.sv
`default_nettype none
// ============================================================================
// Module      : logic_gate_sweep
// Description : Steps every input vector through a selectable gate, holding
//               each for HOLD cycles, and captures the resulting truth table.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_gate_sweep
    import gate_pkg::*;
#(
    parameter int N_IN = 2,
    parameter int HOLD = 5
) (
    input wire logic          clk,
    input wire logic          rst,
    logic_gate_sweep_if.slave bus
);
    localparam int                    c_hold_w    = $clog2(HOLD + 1);
    localparam int                    c_vec_w     = N_IN + 1;
    localparam int                    c_nvec      = 2 ** N_IN;
    localparam logic [c_vec_w-1:0]    c_vec_last  = c_vec_w'(c_nvec - 1);
    localparam logic [c_hold_w-1:0]   c_hold_last = c_hold_w'(HOLD - 1);
    localparam logic                  c_hold_one  = (HOLD == 1);

    sweep_state_e          r_state, w_state_nxt;
    gate_mode_e            r_mode,  w_mode_nxt;
    logic [c_vec_w-1:0]    r_vec,   w_vec_nxt;
    logic [c_hold_w-1:0]   r_hold,  w_hold_nxt;
    logic [c_nvec-1:0]     r_truth, w_truth_nxt;
    logic                  r_out,   w_out_nxt;
    logic                  r_valid, w_valid_nxt;
    logic                  r_busy,  w_busy_nxt;
    logic                  r_done,  w_done_nxt;
    logic                  w_gate_y;
    logic [c_hold_w-1:0]   w_hold_inc;

    assign w_hold_inc = r_hold + c_hold_w'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_mode  <= MODE_AND;
            r_vec   <= '0;
            r_hold  <= '0;
            r_truth <= '0;
            r_out   <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_mode  <= w_mode_nxt;
            r_vec   <= w_vec_nxt;
            r_hold  <= w_hold_nxt;
            r_truth <= w_truth_nxt;
            r_out   <= w_out_nxt;
            r_valid <= w_valid_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // r_valid marks the final hold cycle of the vector currently on vec_o.
    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        w_vec_nxt   = r_vec;
        w_hold_nxt  = r_hold;
        w_truth_nxt = r_truth;
        w_valid_nxt = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = ST_DRIVE;
                    w_mode_nxt  = gate_mode_e'(bus.mode);
                    w_vec_nxt   = '0;
                    w_hold_nxt  = '0;
                    w_truth_nxt = '0;
                    w_valid_nxt = c_hold_one;
                end
            end
            ST_DRIVE: begin
                if (r_valid) begin
                    w_truth_nxt[r_vec[N_IN-1:0]] = r_out;
                    w_hold_nxt = '0;
                    if (r_vec == c_vec_last) begin
                        w_state_nxt = ST_DONE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_vec_nxt   = r_vec + c_vec_w'(1);
                        w_valid_nxt = c_hold_one;
                    end
                end else begin
                    w_hold_nxt  = w_hold_inc;
                    w_valid_nxt = (w_hold_inc == c_hold_last);
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Evaluating on the next-state vector keeps out_o aligned with vec_o.
    gate_eval #(
        .N_IN (N_IN)
    ) u_gate_eval (
        .vec  (w_vec_nxt[N_IN-1:0]),
        .mode (w_mode_nxt),
        .y    (w_gate_y)
    );

    assign w_out_nxt  = (w_state_nxt == ST_DRIVE) && w_gate_y;
    assign w_busy_nxt = (w_state_nxt != ST_IDLE);

    assign bus.vec_o     = r_vec[N_IN-1:0];
    assign bus.out_o     = r_out;
    assign bus.out_valid = r_valid;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.truth_o   = r_truth;
endmodule
`default_nettype wire
